// File: rtl/stg_pkg.sv
// Shared playfield constants, colours and shot FSM encoding
// for the shooter game blocks.
package stg_pkg;

  localparam int MAX_X     = 384;
  localparam int MAX_Y     = 448;
  localparam int BOSS_HX_L = 31;
  localparam int BOSS_HX_R = 32;
  localparam int BOSS_HY_T = 47;
  localparam int BOSS_HY_B = 48;

  localparam logic [11:0] COLOR_NONE    = 12'h000;
  localparam logic [11:0] COLOR_MAGENTA = 12'hF0F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_SPAWN  = 2'd2
  } shot_state_e;

endpackage

// File: rtl/stg_tick_gen.sv
// Game tick strobe: one cycle every TIME_MAX - speed_offset + 1 clocks.
// Shared by the player shot and enemy bullet blocks.
module stg_tick_gen #(
  parameter int TIME_MAX = 4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [25:0] i_speed_offset,
  output logic        o_tick
);

  logic [25:0] r_cnt;
  logic [25:0] w_term;

  assign w_term = 26'(TIME_MAX) - i_speed_offset;
  // >= so a shrinking period never strands the counter past terminal
  assign o_tick = (r_cnt >= w_term);

  always_ff @(posedge clk) begin
    if (reset)       r_cnt <= '0;
    else if (o_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + 26'd1;
  end

endmodule

// File: rtl/player_shot_ctrl.sv
// Player shot manager: spawn, per-tick advance, boss hit test, render.
// Define SHOT_SPREAD_EN to add two side shots to every spawn.
module player_shot_ctrl
  import stg_pkg::*;
#(
  parameter int          NUM_SHOTS     = 8,
  parameter int          TIME_MAX      = 4000,
  parameter int          SHOT_SPEED    = 8,
  parameter int          FIRE_COOLDOWN = 4,
  parameter int          SHOT_HW       = 1,
  parameter int          SHOT_HH       = 4,
  parameter logic [11:0] SHOT_COLOR    = COLOR_MAGENTA
`ifdef SHOT_SPREAD_EN
  , parameter int        SPREAD_DX     = 12
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [25:0] speed_offset,
  input  logic        fire,
  input  logic [9:0]  player_x,
  input  logic [9:0]  player_y,
  input  logic [9:0]  boss_x,
  input  logic [9:0]  boss_y,
  input  logic        boss_die,
  input  logic        hit_ack,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic        is_hit,
  output logic [7:0]  hit_count,
  output logic        shot_on,
  output logic [11:0] rgb_out
);

  localparam int IW = $clog2(NUM_SHOTS);

  shot_state_e r_state, w_state_nxt;

  logic [IW-1:0]        r_idx;
  logic [NUM_SHOTS-1:0] r_act;
  logic [9:0]           r_sx [NUM_SHOTS];
  logic [9:0]           r_sy [NUM_SHOTS];
  logic [7:0]           r_cool;
  logic                 r_is_hit;
  logic [7:0]           r_hits;

  logic          w_tick;
  logic [9:0]    w_sx, w_sy, w_ny;
  logic          w_off, w_in_box, w_hit;
  logic          w_free;
  logic [IW-1:0] w_free_idx;
  logic          w_can_fire, w_spawn, w_sp_first;
  logic [9:0]    w_sp_x;
  logic          w_on;
  logic [9:0]    w_dx, w_dy;

  stg_tick_gen #(.TIME_MAX(TIME_MAX)) u_tick (
    .clk            (clk),
    .reset          (reset),
    .i_speed_offset (speed_offset),
    .o_tick         (w_tick)
  );

  assign w_sx  = r_sx[r_idx];
  assign w_sy  = r_sy[r_idx];
  assign w_ny  = w_sy - 10'(SHOT_SPEED);
  assign w_off = (w_sy < 10'(SHOT_SPEED));

  // 11-bit compares with the margins moved to the other side: no underflow
  assign w_in_box =
    ({1'b0, w_sx} + 11'(BOSS_HX_L) >= {1'b0, boss_x}) &&
    ({1'b0, w_sx} <= {1'b0, boss_x} + 11'(BOSS_HX_R)) &&
    ({1'b0, w_ny} + 11'(BOSS_HY_T) >= {1'b0, boss_y}) &&
    ({1'b0, w_ny} <= {1'b0, boss_y} + 11'(BOSS_HY_B));

  assign w_hit = (r_state == ST_UPDATE) && r_act[r_idx] &&
                 !w_off && !boss_die && w_in_box;

  always_comb begin
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
      if (!r_act[i]) begin
        w_free     = 1'b1;
        w_free_idx = IW'(i);
      end
    end
  end

  assign w_can_fire = (r_cool == 8'd0) && fire &&
                      (player_y >= 10'd16) && w_free;

`ifdef SHOT_SPREAD_EN
  logic [1:0] r_phase;

  assign w_sp_first = (r_phase == 2'd0);

  always_ff @(posedge clk) begin
    if (reset)
      r_phase <= 2'd0;
    else if (r_state == ST_SPAWN && w_state_nxt == ST_SPAWN)
      r_phase <= r_phase + 2'd1;
    else
      r_phase <= 2'd0;
  end
`else
  assign w_sp_first = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_spawn     = 1'b0;
    w_sp_x      = player_x;
    case (r_state)
      ST_IDLE:   if (w_tick) w_state_nxt = ST_UPDATE;
      ST_UPDATE: if (r_idx == IW'(NUM_SHOTS - 1)) w_state_nxt = ST_SPAWN;
      ST_SPAWN: begin
        w_state_nxt = ST_IDLE;
`ifdef SHOT_SPREAD_EN
        case (r_phase)
          2'd0: begin
            w_spawn = w_can_fire;
            if (w_can_fire) w_state_nxt = ST_SPAWN;
          end
          2'd1: begin
            w_state_nxt = ST_SPAWN;
            w_sp_x  = player_x - 10'(SPREAD_DX);
            w_spawn = w_free && (player_x >= 10'(SPREAD_DX));
          end
          default: begin
            w_sp_x  = player_x + 10'(SPREAD_DX);
            w_spawn = w_free &&
                      ({1'b0, player_x} + 11'(SPREAD_DX) < 11'(MAX_X));
          end
        endcase
`else
        w_spawn = w_can_fire;
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx    <= '0;
      r_act    <= '0;
      r_cool   <= 8'd0;
      r_is_hit <= 1'b0;
      r_hits   <= 8'd0;
    end else begin
      if (r_state == ST_UPDATE) r_idx <= r_idx + 1'b1;
      else                      r_idx <= '0;
      if (r_state == ST_UPDATE && r_act[r_idx] && (w_off || w_hit))
        r_act[r_idx] <= 1'b0;
      if (w_spawn) r_act[w_free_idx] <= 1'b1;
      if (r_state == ST_SPAWN && w_sp_first) begin
        if (r_cool != 8'd0) r_cool <= r_cool - 8'd1;
        else if (w_spawn)   r_cool <= 8'(FIRE_COOLDOWN);
      end
      if (w_hit) begin
        r_is_hit <= 1'b1;
        if (r_hits != 8'hFF) r_hits <= r_hits + 8'd1;
      end else if (hit_ack) begin
        r_is_hit <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_UPDATE && r_act[r_idx] && !w_off && !w_hit)
      r_sy[r_idx] <= w_ny;
    if (w_spawn) begin
      r_sx[w_free_idx] <= w_sp_x;
      r_sy[w_free_idx] <= player_y - 10'd16;
    end
  end

  always_comb begin
    w_on = 1'b0;
    w_dx = '0;
    w_dy = '0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      w_dx = (x >= r_sx[i]) ? (x - r_sx[i]) : (r_sx[i] - x);
      w_dy = (y >= r_sy[i]) ? (y - r_sy[i]) : (r_sy[i] - y);
      if (r_act[i] && w_dx <= 10'(SHOT_HW) && w_dy <= 10'(SHOT_HH))
        w_on = 1'b1;
    end
  end

  assign is_hit    = r_is_hit;
  assign hit_count = r_hits;
  assign shot_on   = w_on;
  assign rgb_out   = w_on ? SHOT_COLOR : COLOR_NONE;

endmodule

// File: tb/tb_player_shot_ctrl.sv
// Directed bench for player_shot_ctrl: spawn, movement, hits, ack,
// top-exit, full-slot stall, boss_die and reset mid-pass.
module tb_player_shot_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [25:0] speed_offset;
  logic        fire;
  logic [9:0]  player_x, player_y;
  logic [9:0]  boss_x, boss_y;
  logic        boss_die;
  logic        hit_ack;
  logic [9:0]  x, y;
  logic        is_hit;
  logic [7:0]  hit_count;
  logic        shot_on;
  logic [11:0] rgb_out;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  player_shot_ctrl #(.TIME_MAX(20)) dut (
    .clk          (clk),
    .reset        (reset),
    .speed_offset (speed_offset),
    .fire         (fire),
    .player_x     (player_x),
    .player_y     (player_y),
    .boss_x       (boss_x),
    .boss_y       (boss_y),
    .boss_die     (boss_die),
    .hit_ack      (hit_ack),
    .x            (x),
    .y            (y),
    .is_hit       (is_hit),
    .hit_count    (hit_count),
    .shot_on      (shot_on),
    .rgb_out      (rgb_out)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_tick();
    int n = 0;
    while (dut.w_tick !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_ticks(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      wait_tick();
      repeat (11) @(negedge clk);
    end
  endtask

  task automatic scan(input logic [9:0] sx, input logic [9:0] sy);
    x = sx;
    y = sy;
    #1;
  endtask

  initial begin
    speed_offset = 26'd0;
    fire = 1'b1;
    player_x = 10'd192; player_y = 10'd400;
    boss_x = 10'd192; boss_y = 10'd100;
    boss_die = 1'b1;
    hit_ack = 1'b0;
    x = 10'd192; y = 10'd384;
    reset = 1'b1;

    // reset held with fire pressed
    repeat (3) @(negedge clk);
    scan(10'd192, 10'd384);
    chk("rst_is_hit", is_hit, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_shot_on", shot_on, 0);
    chk("rst_act", dut.r_act, 0);
    reset = 1'b0;

    // first spawn and movement, boss dead
    run_ticks(1);
    chk("sp1_act", dut.r_act, 8'h01);
    chk("sp1_x", dut.r_sx[0], 192);
    chk("sp1_y", dut.r_sy[0], 384);
    scan(10'd193, 10'd388);
    chk("rend_on", shot_on, 1);
    chk("rend_rgb", rgb_out, 12'hF0F);
    scan(10'd194, 10'd384);
    chk("rend_off_x", shot_on, 0);
    chk("rend_rgb0", rgb_out, 0);
    scan(10'd192, 10'd389);
    chk("rend_off_y", shot_on, 0);
    run_ticks(1);
    chk("mv_y", dut.r_sy[0], 376);
    run_ticks(3);
    chk("cool_act", dut.r_act, 8'h01);
    chk("cool_y", dut.r_sy[0], 352);
    run_ticks(1);
    chk("sp2_act", dut.r_act, 8'h03);
    chk("sp2_y1", dut.r_sy[1], 384);
    chk("sp2_y0", dut.r_sy[0], 344);

    // boss hit and ack handling
    fire = 1'b0;
    do_reset();
    player_x = 10'd192; player_y = 10'd168;
    boss_die = 1'b0;
    fire = 1'b1;
    run_ticks(1);
    fire = 1'b0;
    chk("h_act", dut.r_act, 8'h01);
    chk("h_y", dut.r_sy[0], 152);
    chk("h_pre", is_hit, 0);
    run_ticks(1);
    chk("h_freed", dut.r_act, 0);
    chk("h_is_hit", is_hit, 1);
    chk("h_cnt1", hit_count, 1);
    @(negedge clk); hit_ack = 1'b1;
    @(negedge clk); hit_ack = 1'b0;
    chk("ack_clr", is_hit, 0);
    fire = 1'b1;
    run_ticks(4);
    fire = 1'b0;
    chk("h2_act", dut.r_act, 8'h01);
    chk("h2_y", dut.r_sy[0], 152);
    wait_tick();
    @(negedge clk); hit_ack = 1'b1;
    @(negedge clk); hit_ack = 1'b0;
    chk("ack_vs_hit", is_hit, 1);
    repeat (10) @(negedge clk);
    chk("h_cnt2", hit_count, 2);
    chk("h2_freed", dut.r_act, 0);

    // low player, then exit off the top
    do_reset();
    boss_x = 10'd300; boss_y = 10'd300;
    player_x = 10'd50; player_y = 10'd15;
    fire = 1'b1;
    run_ticks(1);
    chk("low_py", dut.r_act, 0);
    player_y = 10'd24;
    run_ticks(1);
    fire = 1'b0;
    chk("top_act", dut.r_act, 8'h01);
    chk("top_y8", dut.r_sy[0], 8);
    run_ticks(1);
    chk("top_y0", dut.r_sy[0], 0);
    scan(10'd50, 10'd0);
    chk("top_on", shot_on, 1);
    run_ticks(1);
    chk("top_gone", dut.r_act, 0);
    scan(10'd50, 10'd1016);
    chk("no_wrap", shot_on, 0);
    scan(10'd50, 10'd0);
    chk("top_off", shot_on, 0);

    // fill all slots through a dead boss
    do_reset();
    player_x = 10'd100; player_y = 10'd336;
    boss_x = 10'd100; boss_y = 10'd200;
    boss_die = 1'b1;
    fire = 1'b1;
    run_ticks(36);
    chk("full_act", dut.r_act, 8'hFF);
    chk("full_cool", dut.r_cool, 4);
    run_ticks(5);
    chk("stall_act", dut.r_act, 8'hFF);
    chk("stall_cool", dut.r_cool, 0);
    chk("die_hits", hit_count, 0);
    chk("die_is_hit", is_hit, 0);
    run_ticks(1);
    chk("refill_act", dut.r_act, 8'hFF);
    chk("refill_y", dut.r_sy[0], 320);
    chk("refill_cool", dut.r_cool, 4);

    // reset in the middle of an update pass
    wait_tick();
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_act", dut.r_act, 0);
    chk("mid_rst_st", dut.r_state, 0);
    chk("mid_rst_cool", dut.r_cool, 0);
    reset = 1'b0;
    fire = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
